// File: rtl/uart_framed.sv
// uart_framed: packet-oriented UART. The TX side serialises a W_OUT-bit packet
// as NUM_WORDS back-to-back UART frames. The RX side reassembles the same number
// of frames into one packet and reports overrun, parity and framing errors.
module uart_framed #(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 16,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_OUT-1:0] s_data,
    output logic             tx,
    input  logic             rx,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W_OUT-1:0] m_data,
    output logic [2:0]       m_error
);
    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CNT_W     = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W     = $clog2(BITS_PER_WORD + 1);
    localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(NUM_WORDS - 1);
    localparam logic [WORD_W-1:0] WORD_ONE   = WORD_W'(1);
    localparam logic              HAS_PARITY = (PARITY != 0);
    localparam logic              ODD_PARITY = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t             tx_state, tx_state_d;
    logic [CNT_W-1:0]   tx_cnt, tx_cnt_d;
    logic [BIT_W-1:0]   tx_bit, tx_bit_d;
    logic [WORD_W-1:0]  tx_word, tx_word_d;
    logic [W_OUT-1:0]   tx_buf, tx_buf_d;
    logic               tx_par, tx_par_d;
    logic               tx_d;
    logic               s_ready_d;

    // TX state, counters, packet shift register and registered line/ready outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_word  <= '0;
            tx_buf   <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            s_ready  <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the values from before this edge.
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_word  <= tx_word_d;
            tx_buf   <= tx_buf_d;
            tx_par   <= tx_par_d;
            tx       <= tx_d;
            s_ready  <= s_ready_d;
        end
    end

    // TX next state: the packet is shifted right one bit per data bit, so word 0
    // goes first and each word LSB first; tx is decoded from the next state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can infer a latch.
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_word_d  = tx_word;
        tx_buf_d   = tx_buf;
        tx_par_d   = tx_par;

        case (tx_state)
            ST_IDLE: begin
                if (s_valid && s_ready) begin
                    tx_state_d = ST_START;
                    tx_buf_d   = s_data;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_word_d  = '0;
                end
            end
            ST_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_par_d   = 1'b0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_d = '0;
                    tx_par_d = tx_par ^ tx_buf[0];
                    tx_buf_d = {1'b0, tx_buf[W_OUT-1:1]};
                    if (tx_bit == DATA_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        tx_bit_d = tx_bit + BIT_ONE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit == STOP_LAST) begin
                        tx_bit_d = '0;
                        if (tx_word == WORD_LAST) begin
                            tx_word_d  = '0;
                            tx_state_d = ST_IDLE;
                        end else begin
                            tx_word_d  = tx_word + WORD_ONE;
                            tx_state_d = ST_START;
                        end
                    end else begin
                        tx_bit_d = tx_bit + BIT_ONE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt + CNT_ONE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        case (tx_state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_buf_d[0];
            ST_PARITY: tx_d = tx_par_d ^ ODD_PARITY;
            default:   tx_d = 1'b1;
        endcase

        s_ready_d = (tx_state_d == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic               rx_meta, rx_sync, rx_prev;
    state_t             rx_state, rx_state_d;
    logic [CNT_W-1:0]   rx_cnt, rx_cnt_d;
    logic [BIT_W-1:0]   rx_bit, rx_bit_d;
    logic [WORD_W-1:0]  rx_word, rx_word_d;
    logic [W_OUT-1:0]   rx_pkt, rx_pkt_d;
    logic               rx_par, rx_par_d;
    logic               rx_perr, rx_perr_d;
    logic               rx_ferr, rx_ferr_d;
    logic               m_valid_d;
    logic [W_OUT-1:0]   m_data_d;
    logic [2:0]         m_error_d;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection;
    // all reset high so leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state, counters, assembly register, sticky errors and output packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_word  <= '0;
            rx_pkt   <= '0;
            rx_par   <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_error  <= '0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_word  <= rx_word_d;
            rx_pkt   <= rx_pkt_d;
            rx_par   <= rx_par_d;
            rx_perr  <= rx_perr_d;
            rx_ferr  <= rx_ferr_d;
            m_valid  <= m_valid_d;
            m_data   <= m_data_d;
            m_error  <= m_error_d;
        end
    end

    // RX next state: half-bit check of the start bit, then one mid-bit sample per
    // bit; data bits shift in from the top so word 0 ends up in the low bits.
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_word_d  = rx_word;
        rx_pkt_d   = rx_pkt;
        rx_par_d   = rx_par;
        rx_perr_d  = rx_perr;
        rx_ferr_d  = rx_ferr;
        m_valid_d  = m_valid && !m_ready;
        m_data_d   = m_data;
        m_error_d  = m_error;

        case (rx_state)
            ST_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = '0;
                end
            end
            ST_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_bit_d   = '0;
                        rx_par_d   = 1'b0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_d = '0;
                    rx_pkt_d = {rx_sync, rx_pkt[W_OUT-1:1]};
                    rx_par_d = rx_par ^ rx_sync;
                    if (rx_bit == DATA_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit + BIT_ONE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = ST_STOP;
                    if ((rx_par ^ rx_sync) != ODD_PARITY) begin
                        rx_perr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_d  = '0;
                    rx_ferr_d = rx_ferr | ~rx_sync;
                    if (rx_bit == STOP_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = ST_IDLE;
                        if (rx_word == WORD_LAST) begin
                            rx_word_d = '0;
                            m_valid_d = 1'b1;
                            m_data_d  = rx_pkt;
                            m_error_d = {m_valid && !m_ready, rx_perr, rx_ferr | ~rx_sync};
                            rx_perr_d = 1'b0;
                            rx_ferr_d = 1'b0;
                        end else begin
                            rx_word_d = rx_word + WORD_ONE;
                        end
                    end else begin
                        rx_bit_d = rx_bit + BIT_ONE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt + CNT_ONE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_framed.sv
// tb_uart_framed: two looped-back instances, one with even parity and one with
// default parameters, driven by a directed sequence with a packet scoreboard.
module tb_uart_framed;
    localparam int CPP       = 16;
    localparam int BPW       = 8;
    localparam int W         = 16;
    localparam int NUM_WORDS = W / BPW;
    localparam int FB_E      = 2 + BPW + 1;   // frame bits with parity, one stop bit
    localparam int FB_N      = 2 + BPW;       // frame bits without parity
    localparam int LEN_N     = NUM_WORDS * FB_N * CPP;

    typedef struct packed {
        logic [W-1:0] data;
        logic [2:0]   err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic         e_s_valid, e_s_ready, e_tx, e_rx, e_m_valid, e_m_ready, e_flip;
    logic [W-1:0] e_s_data, e_m_data;
    logic [2:0]   e_m_error;

    logic         n_s_valid, n_s_ready, n_tx, n_rx, n_m_valid, n_m_ready, n_glitch;
    logic [W-1:0] n_s_data, n_m_data;
    logic [2:0]   n_m_error;

    exp_t q_e[$];
    exp_t q_n[$];
    exp_t e_got, n_got;

    int errors = 0;
    int checks = 0;
    int cnt;

    assign e_rx = e_tx ^ e_flip;
    assign n_rx = n_tx & ~n_glitch;

    always #5 clk = ~clk;

    uart_framed #(
        .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW), .W_OUT(W), .PARITY(2), .STOP_BITS(1)
    ) u_even (
        .clk(clk), .rst(rst),
        .s_valid(e_s_valid), .s_ready(e_s_ready), .s_data(e_s_data),
        .tx(e_tx), .rx(e_rx),
        .m_valid(e_m_valid), .m_ready(e_m_ready), .m_data(e_m_data), .m_error(e_m_error)
    );

    uart_framed u_none (
        .clk(clk), .rst(rst),
        .s_valid(n_s_valid), .s_ready(n_s_ready), .s_data(n_s_data),
        .tx(n_tx), .rx(n_rx),
        .m_valid(n_m_valid), .m_ready(n_m_ready), .m_data(n_m_data), .m_error(n_m_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one packet; optionally push the packet the receiver should deliver.
    task automatic send(input bit ev, input logic [W-1:0] data, input bit push,
                        input logic [2:0] err, input bit hold);
        exp_t e;
        e.data = data;
        e.err  = err;
        check(ev ? "e_accept_ready" : "n_accept_ready", 32'(ev ? e_s_ready : n_s_ready), 1);
        if (ev) begin
            e_s_valid = 1'b1;
            e_s_data  = data;
            if (push) q_e.push_back(e);
        end else begin
            n_s_valid = 1'b1;
            n_s_data  = data;
            if (push) q_n.push_back(e);
        end
        tick();
        if (ev) begin
            e_s_valid = 1'b0;
            e_s_data  = ~data;
        end else begin
            n_s_valid = hold;
            n_s_data  = ~data;
        end
    endtask

    // Compare tx and s_ready every cycle of a packet against a frame model,
    // optionally inverting the parity bit of one word on the looped rx line.
    task automatic frame_check(input bit ev, input logic [W-1:0] data,
                               input int flip_word, input bit scramble);
        int fb, len, bad, idx, w, p;
        logic [BPW-1:0] wd;
        logic exp_tx;
        fb  = ev ? FB_E : FB_N;
        len = NUM_WORDS * fb * CPP;
        bad = 0;
        for (int k = 1; k <= len; k++) begin
            idx = (k - 1) / CPP;
            w   = idx / fb;
            p   = idx % fb;
            wd  = data[w*BPW +: BPW];
            if (p == 0)                      exp_tx = 1'b0;
            else if (p <= BPW)               exp_tx = wd[p-1];
            else if (ev && (p == BPW + 1))   exp_tx = ^wd;
            else                             exp_tx = 1'b1;
            if ((ev ? e_tx : n_tx) !== exp_tx || (ev ? e_s_ready : n_s_ready) !== 1'b0) bad++;
            if (ev) e_flip = (w == flip_word) && (p == BPW + 1);
            if (scramble) n_s_data = W'($urandom);
            tick();
        end
        e_flip = 1'b0;
        check(ev ? "e_tx_wave_bad_cycles" : "n_tx_wave_bad_cycles", 32'(bad), 0);
        check(ev ? "e_s_ready_rise" : "n_s_ready_rise", 32'(ev ? e_s_ready : n_s_ready), 1);
        check(ev ? "e_tx_idle_after" : "n_tx_idle_after", 32'(ev ? e_tx : n_tx), 1);
    endtask

    // Scoreboard for the even-parity instance: compare on each handshake.
    always @(negedge clk) begin
        if (!rst && e_m_valid && e_m_ready) begin
            checks++;
            assert (q_e.size() != 0) else begin
                errors++;
                $error("FAIL e_unexpected_pkt: observed data %h, expected no packet", e_m_data);
            end
            if (q_e.size() != 0) begin
                e_got = q_e.pop_front();
                check("e_pkt_data", 32'(e_m_data), 32'(e_got.data));
                check("e_pkt_err", 32'(e_m_error), 32'(e_got.err));
            end
        end
    end

    // Scoreboard for the default instance: compare on each handshake.
    always @(negedge clk) begin
        if (!rst && n_m_valid && n_m_ready) begin
            checks++;
            assert (q_n.size() != 0) else begin
                errors++;
                $error("FAIL n_unexpected_pkt: observed data %h, expected no packet", n_m_data);
            end
            if (q_n.size() != 0) begin
                n_got = q_n.pop_front();
                check("n_pkt_data", 32'(n_m_data), 32'(n_got.data));
                check("n_pkt_err", 32'(n_m_error), 32'(n_got.err));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        e_s_valid = 1'b0; e_s_data = '0; e_m_ready = 1'b1; e_flip   = 1'b0;
        n_s_valid = 1'b0; n_s_data = '0; n_m_ready = 1'b1; n_glitch = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_e_tx", 32'(e_tx), 1);
        check("rst_e_s_ready", 32'(e_s_ready), 0);
        check("rst_e_m_valid", 32'(e_m_valid), 0);
        check("rst_e_m_data", 32'(e_m_data), 0);
        check("rst_e_m_error", 32'(e_m_error), 0);
        check("rst_n_tx", 32'(n_tx), 1);
        check("rst_n_s_ready", 32'(n_s_ready), 0);
        check("rst_n_m_valid", 32'(n_m_valid), 0);
        rst = 1'b0;
        tick();
        check("e_ready_after_rst", 32'(e_s_ready), 1);
        check("n_ready_after_rst", 32'(n_s_ready), 1);

        // Even parity loopback of 16'hA55A
        send(1'b1, 16'hA55A, 1'b1, 3'b000, 1'b0);
        frame_check(1'b1, 16'hA55A, -1, 1'b0);
        check("e_a55a_drained", 32'(q_e.size()), 0);

        // Parity bit of word 1 inverted on the line
        send(1'b1, 16'hA55A, 1'b1, 3'b010, 1'b0);
        frame_check(1'b1, 16'hA55A, 1, 1'b0);
        check("e_perr_drained", 32'(q_e.size()), 0);

        // Short low glitch must be rejected, then a normal packet
        n_glitch = 1'b1;
        repeat (4) tick();
        n_glitch = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3 * CPP; i++) begin
            if (n_m_valid !== 1'b0) cnt++;
            tick();
        end
        check("glitch_no_m_valid", 32'(cnt), 0);
        send(1'b0, 16'h1234, 1'b1, 3'b000, 1'b0);
        frame_check(1'b0, 16'h1234, -1, 1'b0);
        check("n_1234_drained", 32'(q_n.size()), 0);

        // Overrun: consumer stalled across two packets
        n_m_ready = 1'b0;
        send(1'b0, 16'h0001, 1'b0, 3'b000, 1'b0);
        frame_check(1'b0, 16'h0001, -1, 1'b0);
        check("ovr_first_valid", 32'(n_m_valid), 1);
        check("ovr_first_data", 32'(n_m_data), 32'h0001);
        check("ovr_first_err", 32'(n_m_error), 0);
        send(1'b0, 16'h0002, 1'b1, 3'b100, 1'b0);
        frame_check(1'b0, 16'h0002, -1, 1'b0);
        check("ovr_second_valid", 32'(n_m_valid), 1);
        check("ovr_second_data", 32'(n_m_data), 32'h0002);
        check("ovr_second_err", 32'(n_m_error), 32'b100);
        n_m_ready = 1'b1;
        tick();
        check("ovr_valid_cleared", 32'(n_m_valid), 0);
        check("ovr_drained", 32'(q_n.size()), 0);

        // Reset in the middle of word 0
        send(1'b0, 16'hBEEF, 1'b0, 3'b000, 1'b0);
        repeat (4 * CPP) tick();
        rst = 1'b1;
        tick();
        check("midrst_tx_high", 32'(n_tx), 1);
        check("midrst_s_ready_low", 32'(n_s_ready), 0);
        rst = 1'b0;
        tick();
        check("midrst_s_ready_high", 32'(n_s_ready), 1);
        cnt = 0;
        for (int i = 0; i < LEN_N; i++) begin
            if (n_m_valid !== 1'b0 || n_tx !== 1'b1) cnt++;
            tick();
        end
        check("midrst_quiet_cycles", 32'(cnt), 0);

        // s_valid held with s_data changing; back-to-back accept
        send(1'b0, 16'hC3A5, 1'b1, 3'b000, 1'b1);
        frame_check(1'b0, 16'hC3A5, -1, 1'b1);
        send(1'b0, 16'h5AC3, 1'b1, 3'b000, 1'b0);
        frame_check(1'b0, 16'h5AC3, -1, 1'b0);
        repeat (4) tick();

        check("final_e_queue_empty", 32'(q_e.size()), 0);
        check("final_n_queue_empty", 32'(q_n.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
